// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin input/output FIFO scheduler.
//   NUM_PORTS  : number of input FIFOs and of output FIFOs
//   PORT_W     : width of a port index
//   stage_e    : valid flag carried by each pipeline stage
//   dest_field : extracts the 2-bit destination field of a FIFO word
package arbitro_rr_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;

    typedef enum logic {
        STG_IDLE  = 1'b0,
        STG_VALID = 1'b1
    } stage_e;

    // The word is zero-extended to 32 bits by the caller so the helper stays
    // independent of the instantiating module's DATA_W.
    function automatic logic [PORT_W-1:0] dest_field(input logic [31:0] word,
                                                     input int unsigned lo);
        logic [31:0] sh;
        sh = word >> lo;
        return sh[PORT_W-1:0];
    endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Combinational grant picker.
//   req     in  4  eligible ports
//   last    in  2  previously granted port (round-robin pointer)
//   mode_rr in  1  1 = rotate from last+1, 0 = lowest index wins
//   gnt_idx out 2  winning port index (0 when no request)
//   any     out 1  at least one request present
module rr_pick
    import arbitro_rr_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    input  logic                 mode_rr,
    output logic [PORT_W-1:0]    gnt_idx,
    output logic                 any
);

    logic              found;
    logic [PORT_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = |req;
        found   = 1'b0;
        cand    = '0;
        if (mode_rr) begin
            // Truncation to PORT_W bits provides the modulo-4 wrap.
            for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
                cand = PORT_W'(32'(last) + i);
                if (!found && req[cand]) begin
                    gnt_idx = cand;
                    found   = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!found && req[i]) begin
                    gnt_idx = PORT_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin scheduler between four input FIFOs and four output FIFOs.
// Three registered stages: ISSUE (pop), FETCH (mux select), ROUTE (push).
//   clk             in   1       rising-edge clock
//   reset           in   1       synchronous, active-high
//   mode_rr         in   1       1 = round robin, 0 = fixed priority P0>P1>P2>P3
//   empty_in        in   4       empty flags of input FIFOs
//   almost_full_out in   4       almost_full flags of output FIFOs
//   data_in         in   DATA_W  input mux output, valid while stage 2 is valid
//   pop             out  4       one-hot pop to input FIFOs
//   select          out  2       input mux select
//   push            out  4       one-hot push to output FIFOs
//   data_out        out  DATA_W  word written with push
//   idle            out  1       nothing queued and nothing in flight
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned DEST_LO = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_rr,
    input  logic [3:0]        empty_in,
    input  logic [3:0]        almost_full_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [3:0]        pop,
    output logic [1:0]        select,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out,
    output logic              idle
);

    logic [NUM_PORTS-1:0] pop_q,        pop_d;
    logic [PORT_W-1:0]    last_grant_q, last_grant_d;
    stage_e               v1_q,         v1_d;
    logic [PORT_W-1:0]    g1_q,         g1_d;
    stage_e               v2_q,         v2_d;
    logic [PORT_W-1:0]    select_q,     select_d;
    logic [NUM_PORTS-1:0] push_q,       push_d;
    logic [DATA_W-1:0]    data_out_q,   data_out_d;
    logic                 idle_q,       idle_d;

    logic [NUM_PORTS-1:0] req;
    logic [PORT_W-1:0]    pick_idx;
    logic                 pick_any;
    logic                 issue;
    logic [PORT_W-1:0]    dest;

    // The port popped last edge is masked: its empty flag lags by one cycle.
    assign req   = ~empty_in & ~pop_q;
    assign issue = (almost_full_out == '0) && pick_any;
    assign dest  = dest_field(32'(data_in), DEST_LO);

    rr_pick u_pick (
        .req     (req),
        .last    (last_grant_q),
        .mode_rr (mode_rr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        pop_d        = '0;
        v1_d         = STG_IDLE;
        g1_d         = g1_q;
        last_grant_d = last_grant_q;
        select_d     = g1_q;
        v2_d         = v1_q;
        push_d       = '0;
        data_out_d   = data_out_q;
        idle_d       = (v1_q == STG_IDLE) && (v2_q == STG_IDLE) &&
                       (push_q == '0) && (&empty_in);

        if (issue) begin
            pop_d[pick_idx] = 1'b1;
            v1_d            = STG_VALID;
            g1_d            = pick_idx;
            last_grant_d    = pick_idx;
        end

        if (v2_q == STG_VALID) begin
            push_d[dest] = 1'b1;
            data_out_d   = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q        <= '0;
            last_grant_q <= '1;
            v1_q         <= STG_IDLE;
            g1_q         <= '0;
            v2_q         <= STG_IDLE;
            select_q     <= '0;
            push_q       <= '0;
            data_out_q   <= '0;
            idle_q       <= 1'b1;
        end else begin
            pop_q        <= pop_d;
            last_grant_q <= last_grant_d;
            v1_q         <= v1_d;
            g1_q         <= g1_d;
            v2_q         <= v2_d;
            select_q     <= select_d;
            push_q       <= push_d;
            data_out_q   <= data_out_d;
            idle_q       <= idle_d;
        end
    end

    assign pop      = pop_q;
    assign select   = select_q;
    assign push     = push_q;
    assign data_out = data_out_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: behavioural FIFO environment plus a reference
// scheduler model that predicts pop/select/push/data_out/idle per cycle.
module tb_arbitro_rr;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_rr;
    logic [3:0] empty_in;
    logic [3:0] almost_full_out;
    logic [5:0] data_in;
    logic [3:0] pop;
    logic [1:0] select;
    logic [3:0] push;
    logic [5:0] data_out;
    logic       idle;

    always #5 clk = ~clk;

    arbitro_rr #(.DATA_W(6), .DEST_LO(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .mode_rr         (mode_rr),
        .empty_in        (empty_in),
        .almost_full_out (almost_full_out),
        .data_in         (data_in),
        .pop             (pop),
        .select          (select),
        .push            (push),
        .data_out        (data_out),
        .idle            (idle)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Input FIFO storage shared by environment (ehead) and model (mhead).
    logic [5:0] ebuf [4][512];
    int         ehead[4];
    int         etail[4];
    int         mhead[4];
    logic [5:0] rdata[4];

    // Reference model state.
    int         mprev;
    int         mlast;
    int         mg1;
    bit         pv[4];
    logic [5:0] pw[4];
    logic [3:0] exp_pop;
    logic [3:0] exp_push;
    logic [5:0] exp_dout;
    logic [1:0] exp_sel;
    logic       exp_idle;

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic update_inputs();
        for (int i = 0; i < 4; i++) empty_in[i] = (ehead[i] == etail[i]);
        data_in = rdata[select];
    endtask

    task automatic load(input int p, input logic [5:0] w);
        ebuf[p][etail[p]] = w;
        etail[p]++;
        update_inputs();
    endtask

    function automatic bit quiet();
        bit q;
        q = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (pv[i]) q = 1'b0;
            if (mhead[i] != etail[i]) q = 1'b0;
        end
        return q;
    endfunction

    // Predict what the DUT shows after the coming edge, from the rules.
    task automatic model_step();
        int w;
        bit allempty;
        if (reset) begin
            for (int k = 0; k < 4; k++) pv[k] = 1'b0;
            exp_pop  = 4'b0;
            exp_push = 4'b0;
            exp_dout = 6'b0;
            exp_sel  = 2'b0;
            exp_idle = 1'b1;
            mlast    = 3;
            mprev    = -1;
            mg1      = 0;
            return;
        end
        allempty = 1'b1;
        for (int i = 0; i < 4; i++) if (mhead[i] != etail[i]) allempty = 1'b0;
        w = -1;
        if (almost_full_out == 4'b0) begin
            for (int s = 0; s < 4; s++) begin
                int c;
                c = mode_rr ? (mlast + 1 + s) % 4 : s;
                if (w < 0 && c != mprev && mhead[c] != etail[c]) w = c;
            end
        end
        for (int k = 3; k >= 1; k--) begin
            pv[k] = pv[k-1];
            pw[k] = pw[k-1];
        end
        exp_sel = 2'(mg1);
        pv[0]   = (w >= 0);
        if (w >= 0) begin
            pw[0] = ebuf[w][mhead[w]];
            mhead[w]++;
            mlast = w;
            mg1   = w;
        end
        mprev    = w;
        exp_pop  = (w >= 0) ? onehot(w) : 4'b0;
        exp_push = pv[2] ? onehot(int'(pw[2][5:4])) : 4'b0;
        if (pv[2]) exp_dout = pw[2];
        exp_idle = !pv[1] && !pv[2] && !pv[3] && allempty;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && ehead[i] != etail[i]) begin
                rdata[i] = ebuf[i][ehead[i]];
                ehead[i]++;
            end
        end
        update_inputs();
        chk("pop",      8'(pop),      8'(exp_pop));
        chk("push",     8'(push),     8'(exp_push));
        chk("data_out", 8'(data_out), 8'(exp_dout));
        chk("select",   8'(select),   8'(exp_sel));
        chk("idle",     8'(idle),     8'(exp_idle));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            tick();
            n++;
        end
        chk("drain_bound", 8'(quiet()), 8'd1);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ehead[i] = 0;
            etail[i] = 0;
            mhead[i] = 0;
            rdata[i] = 6'b0;
            pv[i]    = 1'b0;
            pw[i]    = 6'b0;
        end
        mprev = -1;
        mlast = 3;
        mg1   = 0;
        reset = 1'b1;
        mode_rr = 1'b1;
        almost_full_out = 4'b0;
        update_inputs();

        // Reset held two cycles with every input non-empty; then RR fairness.
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 4; j++) load(p, 6'($urandom_range(0, 63)));
        tick();
        tick();
        reset = 1'b0;
        drain(40);

        // Fixed priority: P0 x3, P2 x2, then a lone P0 stream.
        mode_rr = 1'b0;
        for (int j = 0; j < 3; j++) load(0, 6'($urandom_range(0, 63)));
        for (int j = 0; j < 2; j++) load(2, 6'($urandom_range(0, 63)));
        drain(30);
        for (int j = 0; j < 4; j++) load(0, 6'($urandom_range(0, 63)));
        drain(30);

        // Backpressure from F1 for five cycles mid-stream.
        mode_rr = 1'b1;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 5; j++) load(p, 6'($urandom_range(0, 63)));
        tick();
        tick();
        tick();
        almost_full_out = 4'b0010;
        for (int j = 0; j < 5; j++) tick();
        almost_full_out = 4'b0000;
        drain(60);

        // Four consecutive words all bound for F3.
        for (int j = 0; j < 2; j++) begin
            load(1, {2'b11, 4'($urandom_range(0, 15))});
            load(2, {2'b11, 4'($urandom_range(0, 15))});
        end
        drain(30);

        // Reset the cycle after a pop; pointer returns so P0 wins next.
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 3; j++) load(p, 6'($urandom_range(0, 63)));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < 4; p++) load(p, 6'($urandom_range(0, 63)));
        drain(60);

        // Random traffic with mode and backpressure changes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                load(int'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
            if ($urandom_range(0, 7) == 0) mode_rr = 1'($urandom_range(0, 1));
            almost_full_out = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            tick();
        end
        almost_full_out = 4'b0;
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
